// File: rtl/risc_ctrl_pkg.sv
// Shared types and encodings for the RISC instruction-sequencing controller.
package risc_ctrl_pkg;

  typedef enum logic [3:0] {
    StWait,
    StLoadIr,
    StDecode,
    StGetA,
    StGetB,
    StExec,
    StWriteReg,
    StWriteImm,
    StHalt,
    StIllegal
  } state_e;

  // Instruction class latched in DECODE so EXEC can stay a pure function of registered state.
  typedef enum logic [1:0] {
    KindOther,
    KindMovReg,
    KindCmp
  } kind_e;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;
  localparam logic [1:0] VSEL_RSVD  = 2'b11;

endpackage

// File: rtl/risc_controller.sv
// Moore sequencer for the simple RISC datapath: fetch, decode and per-instruction
// register-load/write sequencing, with HALT and illegal-instruction handling.
module risc_controller
  import risc_ctrl_pkg::*;
#(
  parameter bit ENABLE_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic       loadir,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       halted,
  output logic       illegal
);

  state_e r_state, w_state_next;
  kind_e  r_kind, w_kind_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StWait;
      r_kind  <= KindOther;
    end else begin
      r_state <= w_state_next;
      r_kind  <= w_kind_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_kind_next  = r_kind;
    case (r_state)
      StWait:     if (s) w_state_next = StLoadIr;
      StLoadIr:   w_state_next = StDecode;
      StDecode: begin
        w_kind_next = KindOther;
        if (opcode == OPC_MOV && op == OP_MOV_IMM) begin
          w_state_next = StWriteImm;
        end else if (opcode == OPC_MOV && op == OP_MOV_REG) begin
          w_state_next = StGetB;
          w_kind_next  = KindMovReg;
        end else if (opcode == OPC_ALU && op == OP_MVN) begin
          w_state_next = StGetB;
        end else if (opcode == OPC_ALU) begin
          w_state_next = StGetA;
          if (op == OP_CMP) w_kind_next = KindCmp;
        end else if (opcode == OPC_HALT && ENABLE_HALT) begin
          w_state_next = StHalt;
        end else begin
          w_state_next = StIllegal;
        end
      end
      StGetA:     w_state_next = StGetB;
      StGetB:     w_state_next = StExec;
      StExec:     w_state_next = (r_kind == KindCmp) ? StWait : StWriteReg;
      StWriteReg: w_state_next = StWait;
      StWriteImm: w_state_next = StWait;
      StHalt:     w_state_next = StHalt;
      StIllegal:  w_state_next = StWait;
      default:    w_state_next = StWait;
    endcase
  end

  always_comb begin
    w       = 1'b0;
    loadir  = 1'b0;
    nsel    = NSEL_NONE;
    vsel    = VSEL_C;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    write   = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (r_state)
      StWait:   w = 1'b1;
      StLoadIr: loadir = 1'b1;
      StGetA: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      StGetB: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      StExec: begin
        // MOV reg passes Rm through the ALU by forcing the A operand to zero.
        asel  = (r_kind == KindMovReg);
        loadc = (r_kind != KindCmp);
        loads = (r_kind == KindCmp);
      end
      StWriteReg: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      StWriteImm: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      StHalt:    halted = 1'b1;
      StIllegal: illegal = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller: per-instruction output sequences from a vector
// table, plus reset, HALT and back-to-back sequences.
module tb_risc_controller;

  // Output vector: {w, loadir, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
  // halted, illegal}
  localparam logic [15:0] E_WAIT     = 16'h8000;
  localparam logic [15:0] E_LDIR     = 16'h4000;
  localparam logic [15:0] E_DEC      = 16'h0000;
  localparam logic [15:0] E_GETA     = 16'h0900;
  localparam logic [15:0] E_GETB     = 16'h2080;
  localparam logic [15:0] E_EXEC     = 16'h0040;
  localparam logic [15:0] E_EXEC_MOV = 16'h0050;
  localparam logic [15:0] E_EXEC_CMP = 16'h0020;
  localparam logic [15:0] E_WREG     = 16'h1004;
  localparam logic [15:0] E_WIMM     = 16'h0A04;
  localparam logic [15:0] E_HALT     = 16'h0002;
  localparam logic [15:0] E_ILL      = 16'h0001;

  typedef struct {
    string            name;
    logic [2:0]       opc;
    logic [1:0]       op;
    int               n;
    logic [7:0][15:0] seq;
  } vec_t;

  logic clk, reset_n, s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic w, loadir, loada, loadb, loadc, loads, asel, bsel, write, halted, illegal;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic w_nh, loadir_nh, loada_nh, loadb_nh, loadc_nh, loads_nh, asel_nh, bsel_nh;
  logic write_nh, halted_nh, illegal_nh;
  logic [2:0] nsel_nh;
  logic [1:0] vsel_nh;
  logic [15:0] outv, outv_nh;

  int n_pass, n_total;
  vec_t vecs[9];

  risc_controller #(.ENABLE_HALT(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
    .w(w), .loadir(loadir), .nsel(nsel), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .write(write), .halted(halted), .illegal(illegal)
  );

  risc_controller #(.ENABLE_HALT(1'b0)) u_dut_nh (
    .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
    .w(w_nh), .loadir(loadir_nh), .nsel(nsel_nh), .vsel(vsel_nh),
    .loada(loada_nh), .loadb(loadb_nh), .loadc(loadc_nh), .loads(loads_nh),
    .asel(asel_nh), .bsel(bsel_nh), .write(write_nh), .halted(halted_nh),
    .illegal(illegal_nh)
  );

  assign outv = {w, loadir, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
                 halted, illegal};
  assign outv_nh = {w_nh, loadir_nh, nsel_nh, vsel_nh, loada_nh, loadb_nh, loadc_nh,
                    loads_nh, asel_nh, bsel_nh, write_nh, halted_nh, illegal_nh};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0][15:0] mk_seq(input logic [15:0] a, b, c, d, e, f);
    logic [7:0][15:0] r;
    r = '0;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
    return r;
  endfunction

  // opcode/op are only valid during DECODE; garbage elsewhere must be ignored.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " idle"}, outv, E_WAIT);
    s = 1'b1;
    opcode = 3'b011;
    op = ~v.op;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", v.name, k), outv, v.seq[k]);
      if (k == 0) s = 1'b0;
      if (k == 1) begin
        opcode = v.opc;
        op = v.op;
      end
      if (k == 2) begin
        opcode = 3'b111;
        op = 2'b01;
      end
    end
    @(negedge clk);
    chk({v.name, " done"}, outv, E_WAIT);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    vecs[0] = '{"mov_imm", 3'b110, 2'b10, 3, mk_seq(E_LDIR, E_DEC, E_WIMM, 0, 0, 0)};
    vecs[1] = '{"mov_reg", 3'b110, 2'b00, 5,
                mk_seq(E_LDIR, E_DEC, E_GETB, E_EXEC_MOV, E_WREG, 0)};
    vecs[2] = '{"mvn", 3'b101, 2'b11, 5, mk_seq(E_LDIR, E_DEC, E_GETB, E_EXEC, E_WREG, 0)};
    vecs[3] = '{"add", 3'b101, 2'b00, 6,
                mk_seq(E_LDIR, E_DEC, E_GETA, E_GETB, E_EXEC, E_WREG)};
    vecs[4] = '{"cmp", 3'b101, 2'b01, 5,
                mk_seq(E_LDIR, E_DEC, E_GETA, E_GETB, E_EXEC_CMP, 0)};
    vecs[5] = '{"and", 3'b101, 2'b10, 6,
                mk_seq(E_LDIR, E_DEC, E_GETA, E_GETB, E_EXEC, E_WREG)};
    vecs[6] = '{"ill_011", 3'b011, 2'b00, 3, mk_seq(E_LDIR, E_DEC, E_ILL, 0, 0, 0)};
    vecs[7] = '{"ill_mov01", 3'b110, 2'b01, 3, mk_seq(E_LDIR, E_DEC, E_ILL, 0, 0, 0)};
    vecs[8] = '{"ill_000", 3'b000, 2'b11, 3, mk_seq(E_LDIR, E_DEC, E_ILL, 0, 0, 0)};

    // Reset with s high: outputs idle, then s sampled on the release edge.
    reset_n = 1'b0;
    s = 1'b1;
    opcode = 3'b110;
    op = 2'b10;
    repeat (3) @(negedge clk);
    chk("in_reset", outv, E_WAIT);
    chk("in_reset_nh", outv_nh, E_WAIT);
    reset_n = 1'b1;
    @(negedge clk); chk("rel_ldir", outv, E_LDIR);
    @(negedge clk); chk("rel_dec", outv, E_DEC);
    @(negedge clk); chk("rel_wimm", outv, E_WIMM);
    @(negedge clk); chk("b2b_wait", outv, E_WAIT);
    @(negedge clk); chk("b2b_ldir", outv, E_LDIR);
    s = 1'b0;
    @(negedge clk); chk("b2b_dec", outv, E_DEC);
    @(negedge clk); chk("b2b_wimm", outv, E_WIMM);
    @(negedge clk); chk("b2b_done", outv, E_WAIT);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset during GET_B of an ADD: immediate WAIT, no write ever follows.
    @(negedge clk);
    s = 1'b1;
    @(negedge clk); chk("rst_ldir", outv, E_LDIR);
    s = 1'b0;
    opcode = 3'b101;
    op = 2'b00;
    @(negedge clk); chk("rst_dec", outv, E_DEC);
    @(negedge clk); chk("rst_geta", outv, E_GETA);
    @(negedge clk); chk("rst_getb", outv, E_GETB);
    reset_n = 1'b0;
    #1 chk("rst_async", outv, E_WAIT);
    @(negedge clk); chk("rst_hold", outv, E_WAIT);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after[%0d]", k), outv, E_WAIT);
    end

    // HALT with s held high; the ENABLE_HALT=0 instance treats 111 as illegal.
    s = 1'b1;
    opcode = 3'b111;
    op = 2'b00;
    @(negedge clk); chk("halt_ldir", outv, E_LDIR);
    @(negedge clk); chk("halt_dec", outv, E_DEC);
    @(negedge clk); chk("halt_enter", outv, E_HALT);
    chk("nh_illegal", outv_nh, E_ILL);
    @(negedge clk); chk("nh_wait", outv_nh, E_WAIT);
    @(negedge clk); chk("nh_restart", outv_nh, E_LDIR);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("halt_stay[%0d]", k), outv, E_HALT);
    end
    reset_n = 1'b0;
    #1 chk("halt_reset", outv, E_WAIT);
    chk("halt_reset_nh", outv_nh, E_WAIT);
    s = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); chk("halt_cleared", outv, E_WAIT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
